// File: rtl/board_seq.sv
// Board startup/input sequencer: holds the core in reset until PLL lock has been
// stable for a programmable time, debounces push-buttons into press pulses.
module board_seq #(
   parameter int unsigned DEBOUNCE_CYCLES   = 500000,
   parameter int unsigned RESET_HOLD_CYCLES = 1024,
   parameter int unsigned NUM_BTN           = 3
) (
   input  logic               clk_i,
   input  logic               reset_ni,
   input  logic               pll_locked_i,
   input  logic [NUM_BTN-1:0] btn_i,
   output logic               core_reset_o,
   output logic [NUM_BTN-1:0] btn_level_o,
   output logic [NUM_BTN-1:0] btn_press_o,
   output logic [1:0]         state_o,
   output logic               lock_lost_o
);

   localparam logic [1:0] ST_WAIT_LOCK = 2'b00;
   localparam logic [1:0] ST_HOLD      = 2'b01;
   localparam logic [1:0] ST_RUN       = 2'b10;

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = $clog2(RESET_HOLD_CYCLES + 1);
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD_CYCLES - 1);

   logic               lock_meta_q, lock_s_q;
   logic [NUM_BTN-1:0] btn_meta_q, btn_s_q;

   logic [1:0]        state_q, state_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              core_reset_q;
   logic              lock_lost_q, lock_lost_d;

   logic [DB_W-1:0]    db_cnt_q [NUM_BTN];
   logic [DB_W-1:0]    db_cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] level_prev_q;
   logic [NUM_BTN-1:0] press_q, press_d;

   logic run_now;
   logic stay_run;

   always_comb begin
      state_d     = state_q;
      hold_cnt_d  = '0;
      lock_lost_d = lock_lost_q;
      case (state_q)
         ST_WAIT_LOCK: begin
            if (lock_s_q) state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Lock drop takes priority over hold completion.
            if (!lock_s_q)                    state_d = ST_WAIT_LOCK;
            else if (hold_cnt_q == HOLD_LAST) state_d = ST_RUN;
            else                              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
         end
         ST_RUN: begin
            if (!lock_s_q) begin
               state_d     = ST_WAIT_LOCK;
               lock_lost_d = 1'b1;
            end
         end
         default: state_d = ST_WAIT_LOCK;
      endcase
   end

   always_comb begin
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         level_d[i]  = level_q[i];
         db_cnt_d[i] = '0;
         if (btn_s_q[i] != level_q[i]) begin
            if (db_cnt_q[i] == DB_LAST) level_d[i]  = ~level_q[i];
            else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
         end
      end
   end

   // A rise only pulses if RUN is held across the pulse edge, so a lock drop suppresses it.
   assign run_now  = (state_q == ST_RUN);
   assign stay_run = run_now && (state_d == ST_RUN);
   assign press_d  = level_q & ~level_prev_q & {NUM_BTN{stay_run}};

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         lock_meta_q  <= 1'b0;
         lock_s_q     <= 1'b0;
         btn_meta_q   <= '0;
         btn_s_q      <= '0;
         state_q      <= ST_WAIT_LOCK;
         hold_cnt_q   <= '0;
         core_reset_q <= 1'b1;
         lock_lost_q  <= 1'b0;
         level_q      <= '0;
         level_prev_q <= '0;
         press_q      <= '0;
         for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= '0;
      end else begin
         lock_meta_q  <= pll_locked_i;
         lock_s_q     <= lock_meta_q;
         btn_meta_q   <= btn_i;
         btn_s_q      <= btn_meta_q;
         state_q      <= state_d;
         hold_cnt_q   <= hold_cnt_d;
         core_reset_q <= (state_d != ST_RUN);
         lock_lost_q  <= lock_lost_d;
         level_q      <= level_d;
         level_prev_q <= level_q;
         press_q      <= press_d;
         for (int unsigned i = 0; i < NUM_BTN; i++) db_cnt_q[i] <= db_cnt_d[i];
      end
   end

   assign core_reset_o = core_reset_q;
   assign btn_level_o  = level_q & {NUM_BTN{run_now}};
   assign btn_press_o  = press_q;
   assign state_o      = state_q;
   assign lock_lost_o  = lock_lost_q;

endmodule
